zap_predecode_seq_arbiter: RTL and testbench
============================================

Name: zap_predecode_seq_arbiter

Overview:
Arbitrates between micro-op sequencers in predecode (LDM/STM/SWP expander, coprocessor expander, fetch pass-through) that all drive one decode input port. Grants one requester and locks to it until its sequence's last micro-op is accepted. Registers the chosen micro-op toward decode. Honours the standard ZAP stall/clear priority and keeps interrupt flags only on the first micro-op of a sequence.

Parameters:
NUM_REQ, 3, number of requesters; index 0 has highest fixed priority.
MAX_UOPS, 20, watchdog limit on accepted micro-ops per locked sequence (LDM worst case 19).
CNT_W, 5, width of the sequence counter; must satisfy 2^CNT_W > MAX_UOPS.

Ports:
i_clk  in  1  ZAP clock; single clock domain.
i_reset  in  1  synchronous, active-high reset.
i_req_instruction  in  35*NUM_REQ  micro-op per requester; slice k is [35k+34:35k].
i_req_valid  in  NUM_REQ  requester k presents a micro-op.
i_req_last  in  NUM_REQ  micro-op k ends its sequence; single-op requesters tie this high.
i_req_irq  in  NUM_REQ  IRQ tag for requester k.
i_req_fiq  in  NUM_REQ  FIQ tag for requester k.
o_req_ack  out  NUM_REQ  one-hot; requester k's micro-op was taken this cycle (combinational).
i_clear_from_writeback  in  1  flush.
i_data_stall  in  1  stall.
i_clear_from_alu  in  1  flush.
i_stall_from_shifter  in  1  stall.
i_issue_stall  in  1  stall.
o_instruction  out  35  registered micro-op to decode.
o_instruction_valid  out  1  registered valid.
o_irq  out  1  registered IRQ; first micro-op of a sequence only.
o_fiq  out  1  registered FIQ; first micro-op of a sequence only.
o_grant_id  out  clog2(NUM_REQ)  index of the current or last owner.
o_locked  out  1  a sequence is in progress.
o_seq_error  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Cycle priority, highest first: i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_issue_stall, advance.
- Reset or clear: o_instruction_valid=0, o_instruction=0, o_irq=o_fiq=0, unlock, counter=0, o_grant_id=0, o_seq_error=0, o_req_ack=0.
- Any stall: all registers hold; o_req_ack=0; o_seq_error=0.
- States:
  - IDLE (unlocked): on advance, pick the highest-priority requester with valid set. If one is found:
    - register its instruction with valid=1 and its irq/fiq; ack it; set o_grant_id.
    - if last=0: go to LOCKED with counter=1.
    - if last=1: stay in IDLE.
    - If none is valid: output valid=0, irq/fiq=0.
  - LOCKED: only the owner is considered. Owner valid=1 on advance: register it with irq=fiq=0, ack it, counter+1. Owner last=1 returns to IDLE, counter=0. Owner valid=0: bubble (valid=0), lock and counter held. Other requesters are never acked.
- Watchdog: if an accepted non-last micro-op brings the counter to MAX_UOPS, force IDLE, counter=0, and pulse o_seq_error in the cycle after acceptance. The micro-op is still delivered.
- Latency: exactly one cycle from ack to o_instruction.
- o_locked = (state==LOCKED), registered.
- Requesters must hold the micro-op stable until acked.
- A clear in the same cycle as a valid request: no ack, so the request is re-presented.

Optional Feature:
ZAP_SEQ_ARB_RR_EN
- Defined: IDLE selection is round-robin. Search starts at (last granted index + 1) mod NUM_REQ. The pointer updates only on grants made from IDLE. Reset/clear puts the pointer at 0.
- Undefined: fixed priority, index 0 highest; no pointer register.

Test Plan:
- Reset, then req0 valid=1 last=1 instr=0x0E1A00001, irq=1 -> next cycle o_instruction=0x0E1A00001, valid=1, o_irq=1, ack0 was high.
- req1 sends a 4-op sequence (last on op 4) while req0 stays valid from the 2nd cycle -> ops 1-4 of req1 go out back-to-back with only irq on op1; req0 acked on the cycle after op4.
- Locked to req1, req1 valid drops for 2 cycles -> two valid=0 bubbles, o_locked=1, req0 never acked.
- i_data_stall and i_clear_from_alu both high -> outputs held, no ack. Next cycle clear only -> valid=0, o_locked=0.
- req2 streams 20 ops with last=0 -> o_seq_error pulses after op 20; o_locked=0; req0 granted next.
- With ZAP_SEQ_ARB_RR_EN, all three req valid last=1 for 6 cycles -> grants 0,1,2,0,1,2.

Source files
------------

// File: rtl/zap_predecode_seq_arbiter.sv
// rtl/zap_predecode_seq_arbiter.sv - predecode micro-op sequencer arbiter with sequence lock and watchdog
// Optional feature macro: ZAP_SEQ_ARB_RR_EN (round-robin IDLE selection; fixed priority when undefined)
module zap_predecode_seq_arbiter #(
  parameter  int NUM_REQ  = 3,
  parameter  int MAX_UOPS = 20,
  parameter  int CNT_W    = 5,
  localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [35*NUM_REQ-1:0]  i_req_instruction,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ-1:0]     i_req_last,
  input  logic [NUM_REQ-1:0]     i_req_irq,
  input  logic [NUM_REQ-1:0]     i_req_fiq,
  output logic [NUM_REQ-1:0]     o_req_ack,
  input  logic                   i_clear_from_writeback,
  input  logic                   i_data_stall,
  input  logic                   i_clear_from_alu,
  input  logic                   i_stall_from_shifter,
  input  logic                   i_issue_stall,
  output logic [34:0]            o_instruction,
  output logic                   o_instruction_valid,
  output logic                   o_irq,
  output logic                   o_fiq,
  output logic [GID_W-1:0]       o_grant_id,
  output logic                   o_locked,
  output logic                   o_seq_error
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_UOPS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
  logic [34:0]       instr_d;
  logic              valid_d, irq_d, fiq_d, err_d;
  logic [GID_W-1:0]  gid_d;
  logic [34:0]       req_op [NUM_REQ];
  logic              clear, stall, advance;
  logic              found, take;
  logic [GID_W-1:0]  pick, sel;
`ifdef ZAP_SEQ_ARB_RR_EN
  logic [GID_W-1:0]      ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0]  dbl;
  logic [NUM_REQ-1:0]    rot;
  logic [GID_W:0]        sum;
`endif

  // Clear beats stall except that a data stall outranks the ALU clear.
  assign clear   = i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
  assign stall   = i_data_stall | i_stall_from_shifter | i_issue_stall;
  assign advance = ~i_reset & ~clear & ~stall;

  // Split the packed request bus into one micro-op per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_op[k] = i_req_instruction[35*k +: 35];
    end
  end

`ifdef ZAP_SEQ_ARB_RR_EN
  // Round-robin candidate: rotate valids so the search starts at the pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    dbl   = {i_req_valid, i_req_valid};
    rot   = NUM_REQ'(dbl >> ptr_q);
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (GID_W+1)'(k);
        if (sum >= (GID_W+1)'(NUM_REQ)) begin
          sum = sum - (GID_W+1)'(NUM_REQ);
        end
        pick  = sum[GID_W-1:0];
      end
    end
  end
`else
  // Fixed-priority candidate: lowest index with valid set wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        found = 1'b1;
        pick  = GID_W'(k);
      end
    end
  end
`endif

  // While locked only the owner is eligible; ack is suppressed by any stall or clear.
  assign sel       = (state_q == IDLE) ? pick : o_grant_id;
  assign take      = advance & ((state_q == IDLE) ? found : i_req_valid[o_grant_id]);
  assign o_req_ack = take ? (NUM_REQ'(1) << sel) : '0;
  assign o_locked  = (state_q == LOCKED);

  // Next-state and next-output logic for the lock FSM and output register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_next = '0;
    instr_d  = o_instruction;
    valid_d  = o_instruction_valid;
    irq_d    = o_irq;
    fiq_d    = o_fiq;
    gid_d    = o_grant_id;
    err_d    = 1'b0;
`ifdef ZAP_SEQ_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    if (i_reset || clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
      irq_d   = 1'b0;
      fiq_d   = 1'b0;
      gid_d   = '0;
`ifdef ZAP_SEQ_ARB_RR_EN
      ptr_d   = '0;
`endif
    end else if (!stall) begin
      if (take) begin
        instr_d = req_op[sel];
        valid_d = 1'b1;
        irq_d   = (state_q == IDLE) & i_req_irq[sel];
        fiq_d   = (state_q == IDLE) & i_req_fiq[sel];
        gid_d   = sel;
`ifdef ZAP_SEQ_ARB_RR_EN
        if (state_q == IDLE) begin
          ptr_d = (sel == GID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
        end
`endif
        if (i_req_last[sel]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_next = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
          if (cnt_next == MAX_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = LOCKED;
            cnt_d   = cnt_next;
          end
        end
      end else begin
        valid_d = 1'b0;
        irq_d   = 1'b0;
        fiq_d   = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      o_instruction       <= '0;
      o_instruction_valid <= 1'b0;
      o_irq               <= 1'b0;
      o_fiq               <= 1'b0;
      o_grant_id          <= '0;
      o_seq_error         <= 1'b0;
`ifdef ZAP_SEQ_ARB_RR_EN
      ptr_q               <= '0;
`endif
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      o_instruction       <= instr_d;
      o_instruction_valid <= valid_d;
      o_irq               <= irq_d;
      o_fiq               <= fiq_d;
      o_grant_id          <= gid_d;
      o_seq_error         <= err_d;
`ifdef ZAP_SEQ_ARB_RR_EN
      ptr_q               <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_zap_predecode_seq_arbiter.sv
// tb/tb_zap_predecode_seq_arbiter.sv - self-checking bench for zap_predecode_seq_arbiter
module tb_zap_predecode_seq_arbiter;
  localparam int N    = 3;
  localparam int MAXU = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [34:0]     r_ins [N];
  bit              r_v [N], r_l [N], r_i [N], r_f [N];
  logic [35*N-1:0] req_instr;
  logic [N-1:0]    req_valid, req_last, req_irq, req_fiq, req_ack;
  logic            clr_wb = 1'b0, dstall = 1'b0, clr_alu = 1'b0, sh_stall = 1'b0, is_stall = 1'b0;
  logic [34:0]     out_instr;
  logic            out_valid, out_irq, out_fiq, out_locked, out_err;
  logic [1:0]      out_gid;

  assign req_instr = {r_ins[2], r_ins[1], r_ins[0]};
  assign req_valid = {r_v[2], r_v[1], r_v[0]};
  assign req_last  = {r_l[2], r_l[1], r_l[0]};
  assign req_irq   = {r_i[2], r_i[1], r_i[0]};
  assign req_fiq   = {r_f[2], r_f[1], r_f[0]};

  zap_predecode_seq_arbiter dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_instruction(req_instr), .i_req_valid(req_valid), .i_req_last(req_last),
    .i_req_irq(req_irq), .i_req_fiq(req_fiq), .o_req_ack(req_ack),
    .i_clear_from_writeback(clr_wb), .i_data_stall(dstall), .i_clear_from_alu(clr_alu),
    .i_stall_from_shifter(sh_stall), .i_issue_stall(is_stall),
    .o_instruction(out_instr), .o_instruction_valid(out_valid), .o_irq(out_irq), .o_fiq(out_fiq),
    .o_grant_id(out_gid), .o_locked(out_locked), .o_seq_error(out_err)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: owner (-1 when free), accepted-op count, round-robin start.
  bit          ready = 1'b0;
  int          m_owner = -1, m_cnt = 0, m_rr = 0;
  logic [34:0] e_instr = '0;
  bit          e_valid = 0, e_irq = 0, e_fiq = 0, e_err = 0;
  int          e_gid = 0;

  // 0 = flush, 1 = hold, 2 = advance
  function automatic int model_mode();
    if (reset)    return 0;
    if (clr_wb)   return 0;
    if (dstall)   return 1;
    if (clr_alu)  return 0;
    if (sh_stall) return 1;
    if (is_stall) return 1;
    return 2;
  endfunction

  function automatic int model_take();
    int start;
    if (model_mode() != 2) return -1;
    if (m_owner >= 0) return r_v[m_owner] ? m_owner : -1;
`ifdef ZAP_SEQ_ARB_RR_EN
    start = m_rr;
`else
    start = 0;
`endif
    for (int off = 0; off < N; off++) begin
      if (r_v[(start + off) % N]) return (start + off) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int  mode, t;
    bit  first;
    mode = model_mode();
    t    = model_take();
    if (mode == 0) begin
      ready = 1'b1;
      m_owner = -1; m_cnt = 0; m_rr = 0;
      e_instr = '0; e_valid = 0; e_irq = 0; e_fiq = 0; e_gid = 0; e_err = 0;
    end else if (mode == 1) begin
      e_err = 0;
    end else begin
      e_err = 0;
      if (t < 0) begin
        e_valid = 0; e_irq = 0; e_fiq = 0;
      end else begin
        first   = (m_owner < 0);
        e_instr = r_ins[t];
        e_valid = 1;
        e_irq   = first && r_i[t];
        e_fiq   = first && r_f[t];
        e_gid   = t;
        if (first) m_rr = (t + 1) % N;
        if (r_l[t]) begin
          m_owner = -1; m_cnt = 0;
        end else begin
          m_cnt   = first ? 1 : m_cnt + 1;
          m_owner = t;
          if (m_cnt == MAXU) begin
            m_owner = -1; m_cnt = 0; e_err = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int t;
    if (ready) begin
      t = model_take();
      chk("cyc_ack", req_ack, (t >= 0) ? (64'd1 << t) : 64'd0);
      chk("cyc_valid", out_valid, e_valid);
      chk("cyc_irq", out_irq, e_irq);
      chk("cyc_fiq", out_fiq, e_fiq);
      chk("cyc_gid", out_gid, e_gid);
      chk("cyc_locked", out_locked, m_owner >= 0);
      chk("cyc_err", out_err, e_err);
      if (e_valid) chk("cyc_instr", out_instr, e_instr);
    end
  end

  task automatic set_req(int k, bit v, bit l, bit irq, bit fiq, logic [34:0] ins);
    r_v[k] = v; r_l[k] = l; r_i[k] = irq; r_f[k] = fiq; r_ins[k] = ins;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g [6];
    for (int k = 0; k < N; k++) set_req(k, 0, 1, 0, 0, '0);
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_locked", out_locked, 0);
    chk("rst_gid", out_gid, 0);

    // single-op request with IRQ
    set_req(0, 1, 1, 1, 0, 35'h0E1A00001);
    #1 chk("t1_ack", req_ack, 3'b001);
    cyc();
    chk("t1_instr", out_instr, 35'h0E1A00001);
    chk("t1_valid", out_valid, 1);
    chk("t1_irq", out_irq, 1);
    set_req(0, 0, 1, 0, 0, '0);

    // four-op sequence from req1, req0 waiting from the second op
    for (int op = 1; op <= 4; op++) begin
      set_req(1, 1, op == 4, 1, 0, 35'h100 + op);
      if (op >= 2) set_req(0, 1, 1, 0, 0, 35'h0AA);
      #1 chk("t2_ack1", req_ack, 3'b010);
      cyc();
      chk("t2_instr", out_instr, 35'h100 + op);
      chk("t2_irq", out_irq, op == 1);
    end
    set_req(1, 0, 1, 0, 0, '0);
    #1 chk("t2_ack0", req_ack, 3'b001);
    cyc();
    chk("t2_instr0", out_instr, 35'h0AA);
    set_req(0, 0, 1, 0, 0, '0);

    // lock req1, then two bubbles while req0 waits
    set_req(1, 1, 0, 0, 0, 35'h201);
    #1 chk("t3_ack1", req_ack, 3'b010);
    cyc();
    set_req(1, 0, 0, 0, 0, 35'h202);
    set_req(0, 1, 1, 0, 0, 35'h0AB);
    repeat (2) begin
      #1 chk("t3_noack", req_ack, 3'b000);
      cyc();
      chk("t3_bubble", out_valid, 0);
      chk("t3_locked", out_locked, 1);
    end

    // data stall outranks ALU clear; then the clear alone unlocks
    set_req(1, 1, 0, 0, 0, 35'h202);
    dstall = 1'b1; clr_alu = 1'b1;
    #1 chk("t4_stall_ack", req_ack, 3'b000);
    cyc();
    chk("t4_hold_locked", out_locked, 1);
    chk("t4_hold_valid", out_valid, 0);
    dstall = 1'b0;
    #1 chk("t4_clr_ack", req_ack, 3'b000);
    cyc();
    clr_alu = 1'b0;
    chk("t4_clr_valid", out_valid, 0);
    chk("t4_clr_locked", out_locked, 0);
    #1 chk("t4_ack0", req_ack, 3'b001);
    cyc();
    set_req(0, 0, 1, 0, 0, '0);
    set_req(1, 1, 1, 0, 1, 35'h203);
    #1 chk("t4_ack1", req_ack, 3'b010);
    cyc();
    chk("t4_fiq", out_fiq, 1);
    set_req(1, 0, 1, 0, 0, '0);

    // writeback clear beats data stall; shifter and issue stalls hold
    set_req(0, 1, 1, 0, 0, 35'h0AD);
    clr_wb = 1'b1; dstall = 1'b1;
    cyc();
    chk("t5_wb_valid", out_valid, 0);
    clr_wb = 1'b0; dstall = 1'b0; sh_stall = 1'b1;
    cyc();
    sh_stall = 1'b0; is_stall = 1'b1;
    cyc();
    is_stall = 1'b0;
    cyc();
    chk("t5_instr", out_instr, 35'h0AD);
    set_req(0, 0, 1, 0, 0, '0);

    // watchdog: req2 streams MAXU non-last ops
    for (int op = 1; op <= MAXU; op++) begin
      set_req(2, 1, 0, 1, 1, 35'h300 + op);
      if (op >= 5) set_req(0, 1, 1, 0, 0, 35'h0AC);
      #1 chk("t6_ack2", req_ack, 3'b100);
      cyc();
      if (op < MAXU) chk("t6_no_err", out_err, 0);
    end
    chk("t6_err", out_err, 1);
    chk("t6_unlocked", out_locked, 0);
    chk("t6_last_instr", out_instr, 35'h314);
    #1 chk("t6_ack0", req_ack, 3'b001);
    cyc();
    chk("t6_err_drop", out_err, 0);
    set_req(0, 0, 1, 0, 0, '0);
    set_req(2, 0, 1, 0, 0, '0);

    // arbitration order with all three single-op requesters valid
    clr_wb = 1'b1;
    cyc();
    clr_wb = 1'b0;
`ifdef ZAP_SEQ_ARB_RR_EN
    exp_g = '{0, 1, 2, 0, 1, 2};
`else
    exp_g = '{0, 0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < N; k++) set_req(k, 1, 1, 0, 0, 35'h400 + k);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("t7_gid", out_gid, exp_g[c]);
    end
    for (int k = 0; k < N; k++) set_req(k, 0, 1, 0, 0, '0);
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
